sub_bytes_iter: RTL and testbench



---
 rtl/aes_pkg.sv | 25 ++
 rtl/sub_bytes_iter_sbox.sv | 30 +++
 rtl/sub_bytes_iter.sv | 116 +++++++++++
 tb/tb_sub_bytes_iter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES datapath definitions: block geometry, SubBytes engine state
// encoding and lane/group sizing helpers.
package aes_pkg;

    localparam int BLOCK_W = 128;
    localparam int BYTE_W  = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } sbi_state_e;

    function automatic int NUM_GROUPS(input int lanes);
        return (BLOCK_W / BYTE_W) / lanes;
    endfunction

    // Group counter is kept at least one bit wide even when a single group exists.
    function automatic int GRP_WIDTH(input int lanes);
        int ng;
        ng = NUM_GROUPS(lanes);
        return (ng <= 2) ? 1 : $clog2(ng);
    endfunction

endpackage

// File: rtl/sub_bytes_iter_sbox.sv
// Combinational forward AES S-box: one byte in, its substitution out.
module sub_bytes_iter_sbox
    import aes_pkg::*;
(
    input  logic [BYTE_W-1:0] i_byte,
    output logic [BYTE_W-1:0] o_byte
);

    localparam logic [BYTE_W-1:0] SBOX_TBL [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign o_byte = SBOX_TBL[i_byte];

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: LANES S-boxes sweep the 16-byte state in place,
// lowest byte group first, with valid/ready handshakes on both sides.
module sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data
);

    localparam int NBYTES = BLOCK_W / BYTE_W;
    localparam int IDX_W  = $clog2(NBYTES);
    localparam int NG     = NUM_GROUPS(LANES);
    localparam int GW     = GRP_WIDTH(LANES);
    localparam logic [GW-1:0] LAST_GRP = GW'(NG - 1);

    sbi_state_e        r_state;
    sbi_state_e        w_next_state;
    logic [GW-1:0]     r_grp;
    logic [BYTE_W-1:0] r_st       [NBYTES];
    logic [IDX_W-1:0]  w_idx      [LANES];
    logic [BYTE_W-1:0] w_lane_in  [LANES];
    logic [BYTE_W-1:0] w_lane_out [LANES];
    logic              w_load;
    logic              w_last;

    assign w_load = in_valid & in_ready;
    assign w_last = (r_grp == LAST_GRP);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_next_state = ST_BUSY;
            ST_BUSY: if (w_last) w_next_state = ST_DONE;
            ST_DONE: begin
                if (out_ready) begin
                    w_next_state = in_valid ? ST_BUSY : ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // in_ready follows out_ready in DONE so a finished block and a new one can swap in one cycle.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: in_ready = 1'b1;
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            w_idx[k]     = IDX_W'(int'(r_grp) * LANES + k);
            w_lane_in[k] = r_st[w_idx[k]];
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        sub_bytes_iter_sbox u_sbox (
            .i_byte (w_lane_in[k]),
            .o_byte (w_lane_out[k])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grp <= '0;
            for (int i = 0; i < NBYTES; i++) begin
                r_st[i] <= '0;
            end
        end else if (w_load) begin
            r_grp <= '0;
            for (int i = 0; i < NBYTES; i++) begin
                r_st[i] <= in_data[i*BYTE_W +: BYTE_W];
            end
        end else if (r_state == ST_BUSY) begin
            for (int k = 0; k < LANES; k++) begin
                r_st[w_idx[k]] <= w_lane_out[k];
            end
            r_grp <= w_last ? '0 : r_grp + GW'(1);
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < NBYTES; i++) begin
            out_data[i*BYTE_W +: BYTE_W] = r_st[i];
        end
    end

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter at LANES=4, 1 and 16 against a GF(2^8) reference model.
module tb_sub_bytes_iter;

    logic         clk = 1'b0;
    logic         reset;
    logic [2:0]   in_valid;
    logic [2:0]   out_ready;
    logic [2:0]   in_ready;
    logic [2:0]   out_valid;
    logic [127:0] in_data  [3];
    logic [127:0] out_data [3];

    int n_checks = 0;
    int n_errors = 0;
    int lanes_of [3] = '{4, 1, 16};
    logic [7:0] ref_tbl [256];

    always #5 clk = ~clk;

    sub_bytes_iter #(.LANES(4)) u_l4 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0])
    );
    sub_bytes_iter #(.LANES(1)) u_l1 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1])
    );
    sub_bytes_iter #(.LANES(16)) u_l16 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2])
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    // S(x) = affine(x^-1), with 0 mapping to inverse 0.
    function automatic logic [7:0] sbox_model(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        for (int c = 1; c < 256; c++) begin
            if (gmul(x, 8'(c)) == 8'h01) inv = 8'(c);
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_ref(input logic [127:0] x);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[i*8 +: 8] = ref_tbl[x[i*8 +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic run_block(input int d, input logic [127:0] din, input logic [127:0] exp,
                             input string nm);
        int cnt;
        in_data[d]   = din;
        in_valid[d]  = 1'b1;
        out_ready[d] = 1'b1;
        check({nm, " in_ready"}, 128'(in_ready[d]), 128'd1);
        @(posedge clk); #1;
        in_valid[d] = 1'b0;
        in_data[d]  = rand128();
        cnt = 0;
        while (!out_valid[d] && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        check({nm, " latency"}, 128'(cnt), 128'(16 / lanes_of[d]));
        check({nm, " data"}, out_data[d], exp);
        @(posedge clk); #1;
        check({nm, " out_valid drop"}, 128'(out_valid[d]), 128'd0);
    endtask

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
        string        nm;
    } vec_t;

    initial begin
        vec_t         vecs [4];
        logic [127:0] blk  [3];
        logic [127:0] x;
        int           acc_cyc [3];
        int           nacc, nout, cyc, cnt;

        for (int i = 0; i < 256; i++) ref_tbl[i] = sbox_model(8'(i));

        vecs[0] = '{128'h0f0e0d0c0b0a09080706050403020100, 128'h76abd7fe2b670130c56f6bf27b777c63, "fips"};
        vecs[1] = '{{16{8'h00}}, {16{8'h63}}, "all00"};
        vecs[2] = '{{16{8'hff}}, {16{8'h16}}, "allff"};
        vecs[3] = '{{16{8'h53}}, {16{8'hed}}, "all53"};

        reset     = 1'b1;
        in_valid  = '0;
        out_ready = '0;
        for (int d = 0; d < 3; d++) in_data[d] = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            check($sformatf("reset out_valid L%0d", lanes_of[d]), 128'(out_valid[d]), 128'd0);
            check($sformatf("reset out_data L%0d", lanes_of[d]), out_data[d], 128'd0);
            check($sformatf("reset in_ready L%0d", lanes_of[d]), 128'(in_ready[d]), 128'd1);
        end

        for (int i = 0; i < 4; i++) run_block(0, vecs[i].din, vecs[i].dout, vecs[i].nm);

        // Backpressure: hold the result for 10 cycles, then release.
        x = rand128();
        in_data[0] = x; in_valid[0] = 1'b1; out_ready[0] = 1'b0;
        @(posedge clk); #1;
        in_valid[0] = 1'b0; in_data[0] = rand128();
        cnt = 0;
        while (!out_valid[0] && cnt < 40) begin
            @(posedge clk); #1;
            cnt++;
        end
        for (int c = 0; c < 10; c++) begin
            check($sformatf("bp out_valid c%0d", c), 128'(out_valid[0]), 128'd1);
            check($sformatf("bp out_data c%0d", c), out_data[0], sub_ref(x));
            check($sformatf("bp in_ready c%0d", c), 128'(in_ready[0]), 128'd0);
            @(posedge clk); #1;
        end
        out_ready[0] = 1'b1;
        #1;
        check("bp release in_ready", 128'(in_ready[0]), 128'd1);
        @(posedge clk); #1;
        check("bp handshake done", 128'(out_valid[0]), 128'd0);

        // Back-to-back with in_valid and out_ready held high.
        for (int i = 0; i < 3; i++) blk[i] = rand128();
        nacc = 0; nout = 0; cyc = 0;
        in_valid[0] = 1'b1; in_data[0] = blk[0]; out_ready[0] = 1'b1;
        while (nout < 3 && cyc < 100) begin
            if (out_valid[0]) begin
                check($sformatf("b2b out %0d", nout), out_data[0], sub_ref(blk[nout]));
                nout++;
            end
            if (in_ready[0] && nacc < 3) begin
                acc_cyc[nacc] = cyc;
                nacc++;
            end
            @(posedge clk); #1;
            cyc++;
            in_valid[0] = (nacc < 3);
            in_data[0]  = (nacc < 3) ? blk[nacc] : '0;
        end
        in_valid[0] = 1'b0;
        check("b2b outputs seen", 128'(nout), 128'd3);
        check("b2b accept gap 0-1", 128'(acc_cyc[1] - acc_cyc[0]), 128'd5);
        check("b2b accept gap 1-2", 128'(acc_cyc[2] - acc_cyc[1]), 128'd5);
        @(posedge clk); #1;

        // Reset two cycles after acceptance, then a fresh block.
        in_data[0] = rand128(); in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; in_valid[0] = 1'b0;
        check("rst busy out_valid", 128'(out_valid[0]), 128'd0);
        check("rst busy out_data", out_data[0], 128'd0);
        check("rst busy in_ready", 128'(in_ready[0]), 128'd1);
        x = rand128();
        run_block(0, x, sub_ref(x), "post-reset");

        for (int d = 0; d < 3; d++) begin
            for (int r = 0; r < 5; r++) begin
                x = rand128();
                run_block(d, x, sub_ref(x), $sformatf("rand L%0d #%0d", lanes_of[d], r));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
